// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: tick and serial line in, received word and status out.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 i_tick;
    logic                 i_rx;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_rx_done;
    logic                 o_frame_err;

    // master: the receiver that produces bytes; slave: the tick/line source and byte consumer
    modport master (
        input  i_tick,
        input  i_rx,
        output o_data,
        output o_rx_done,
        output o_frame_err
    );

    modport slave (
        output i_tick,
        output i_rx,
        input  o_data,
        input  o_rx_done,
        input  o_frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, mid-bit sampling and stop-bit check.
// Byte and frame error update together with a one-cycle done strobe; no backpressure.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_TICKS = 16
) (
    input  logic       i_clock,
    input  logic       i_reset,
    uart_rx_if.master  bus
);
    localparam int S_W = ($clog2(STOP_TICKS) > 4) ? $clog2(STOP_TICKS) : 4;
    localparam int N_W = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [S_W-1:0]       r_s, w_s_nxt;
    logic [N_W-1:0]       r_n, w_n_nxt;
    logic [DATA_BITS-1:0] r_b, w_b_nxt;
    logic [DATA_BITS-1:0] r_data, w_data_nxt;
    logic                 r_err, w_err_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_rx_meta, r_rx_s;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
            r_data  <= w_data_nxt;
            r_err   <= w_err_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_b_nxt     = r_b;
        w_data_nxt  = r_data;
        w_err_nxt   = r_err;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = START;
                    w_s_nxt     = '0;
                end
            end
            START: begin
                // Tick 8 lands mid-start-bit; a high line there was only a glitch.
                if (bus.i_tick) begin
                    if (r_s == S_W'(7)) begin
                        if (!r_rx_s) begin
                            w_state_nxt = DATA;
                            w_s_nxt     = '0;
                            w_n_nxt     = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (bus.i_tick) begin
                    if (r_s == S_W'(15)) begin
                        w_s_nxt = '0;
                        w_b_nxt = {r_rx_s, r_b[DATA_BITS-1:1]};
                        if (r_n == N_W'(DATA_BITS - 1)) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_n_nxt = r_n + N_W'(1);
                        end
                    end else begin
                        w_s_nxt = r_s + S_W'(1);
                    end
                end
            end
            STOP: begin
                // Leaving at the stop sample lets a following start bit be caught with no gap.
                if (bus.i_tick) begin
                    if (r_s == S_W'(STOP_TICKS - 1)) begin
                        w_data_nxt  = r_b;
                        w_err_nxt   = ~r_rx_s;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_s_nxt = r_s + S_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.o_data      = r_data;
    assign bus.o_frame_err = r_err;
    assign bus.o_rx_done   = r_done;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: default 8N1 instance ticked every 4 clocks, plus a
// 7-bit / 2-stop instance ticked every clock.
module tb_uart_rx;
    typedef struct {
        logic [7:0] data;
        logic       err;
        int         t0;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tdiv;
    int   n_checks;
    int   n_fails;
    exp_t q0[$];
    exp_t q1[$];
    logic prev0, prev1;

    uart_rx_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_if #(.DATA_BITS(7)) bus1 ();

    uart_rx #(.DATA_BITS(8), .STOP_TICKS(16)) dut0 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus0)
    );

    uart_rx #(.DATA_BITS(7), .STOP_TICKS(32)) dut1 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // 16x tick for the default instance every 4 clocks; the other instance ticks every clock.
    initial begin
        tdiv = 0;
        bus0.i_tick = 1'b0;
        bus1.i_tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tdiv = (tdiv + 1) % 4;
            bus0.i_tick = (tdiv == 0);
        end
    end

    // Line helpers: called positioned 1 time unit after a rising edge, return the same way.
    task automatic drive(input int dut, input logic v, input int nclk);
        if (dut == 0) bus0.i_rx = v;
        else          bus1.i_rx = v;
        repeat (nclk) @(posedge clk);
        #1;
    endtask

    task automatic send(input int dut, input logic [7:0] d, input logic stop_v,
                        input bit push, input int rst_bit);
        int   bp;
        int   nb;
        int   sc;
        exp_t e;
        bp = (dut == 0) ? 64 : 16;
        nb = (dut == 0) ? 8 : 7;
        sc = (dut == 0) ? 64 : 32;
        // A low stop bit is cut short so the line is high again before any false start resolves.
        if (!stop_v) sc = (sc * 3) / 4;
        @(posedge clk);
        #1;
        e.data = (dut == 0) ? d : {1'b0, d[6:0]};
        e.err  = ~stop_v;
        e.t0   = cyc;
        if (push) begin
            if (dut == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        drive(dut, 1'b0, bp);
        for (int i = 0; i < nb; i++) begin
            if (i == rst_bit) begin
                drive(dut, d[i], bp / 2);
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                drive(dut, 1'b1, 0);
                return;
            end
            drive(dut, d[i], bp);
        end
        drive(dut, stop_v, sc);
        drive(dut, 1'b1, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(posedge clk);
        end
        check("drain_pending", q0.size() + q1.size(), 0);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (bus0.o_rx_done === 1'b1) begin
            check("dut0_done_width", prev0, 0);
            if (q0.size() == 0) begin
                check("dut0_spurious_done", bus0.o_rx_done, 0);
            end else begin
                e   = q0.pop_front();
                lat = cyc - e.t0;
                check("dut0_data", bus0.o_data, e.data);
                check("dut0_frame_err", bus0.o_frame_err, e.err);
                check("dut0_latency_window", (lat >= 604 && lat <= 616), 1);
            end
        end
        prev0 = bus0.o_rx_done;
    end

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (bus1.o_rx_done === 1'b1) begin
            check("dut1_done_width", prev1, 0);
            if (q1.size() == 0) begin
                check("dut1_spurious_done", bus1.o_rx_done, 0);
            end else begin
                e   = q1.pop_front();
                lat = cyc - e.t0;
                check("dut1_data", bus1.o_data, e.data);
                check("dut1_frame_err", bus1.o_frame_err, e.err);
                check("dut1_latency_window", (lat >= 150 && lat <= 160), 1);
            end
        end
        prev1 = bus1.o_rx_done;
    end

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        prev0     = 1'b0;
        prev1     = 1'b0;
        rst       = 1'b1;
        bus0.i_rx = 1'b1;
        bus1.i_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dut0_data", bus0.o_data, 0);
        check("rst_dut0_done", bus0.o_rx_done, 0);
        check("rst_dut0_ferr", bus0.o_frame_err, 0);
        check("rst_dut1_data", bus1.o_data, 0);
        check("rst_dut1_done", bus1.o_rx_done, 0);
        check("rst_dut1_ferr", bus1.o_frame_err, 0);
        repeat (20) @(posedge clk);
        #1;

        send(0, 8'hA5, 1'b1, 1, -1);
        drain();

        send(0, 8'h00, 1'b1, 1, -1);
        send(0, 8'hFF, 1'b1, 1, -1);
        drain();

        // Three-tick low pulse must be rejected as a glitch.
        drive(0, 1'b0, 12);
        drive(0, 1'b1, 200);
        check("glitch_data_held", bus0.o_data, 8'hFF);
        check("glitch_ferr_held", bus0.o_frame_err, 0);
        send(0, 8'h3C, 1'b1, 1, -1);
        drain();

        send(0, 8'h3C, 1'b0, 1, -1);
        drive(0, 1'b1, 200);
        drain();
        check("ferr_held", bus0.o_frame_err, 1);
        check("ferr_data_held", bus0.o_data, 8'h3C);
        send(0, 8'h55, 1'b1, 1, -1);
        drain();

        send(0, 8'h81, 1'b1, 0, 4);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_data", bus0.o_data, 0);
        check("midrst_ferr", bus0.o_frame_err, 0);
        check("midrst_done", bus0.o_rx_done, 0);
        drive(0, 1'b1, 700);
        check("midrst_data_quiet", bus0.o_data, 0);
        send(0, 8'h7E, 1'b1, 1, -1);
        drain();

        send(1, 8'h5A, 1'b1, 1, -1);
        drain();
        send(1, 8'h2B, 1'b1, 1, -1);
        drain();

        repeat (50) @(posedge clk);
        check("final_q0_empty", q0.size(), 0);
        check("final_q1_empty", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
